// File: rtl/game_phase_sequencer_pkg.sv
// Shared phase enum, default durations and duration helpers for the round sequencer.
package game_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRELIM,
        GAME,
        ANSWER,
        JUDGE,
        POST,
        LOSE,
        WIN
    } phase_t;

    localparam int unsigned DEF_PRELIM_SECS    = 3;
    localparam int unsigned DEF_GAME_SECS_BASE = 20;
    localparam int unsigned DEF_GAME_SECS_STEP = 2;
    localparam int unsigned DEF_GAME_SECS_MIN  = 8;
    localparam int unsigned DEF_ANSWER_SECS    = 10;
    localparam int unsigned DEF_POST_SECS      = 3;

    function automatic logic is_timed(phase_t p);
        return (p == PRELIM) || (p == GAME) || (p == ANSWER) || (p == POST);
    endfunction

    // A zero duration still has to expire on a tick, so it behaves as one second.
    function automatic int unsigned clamp_secs(int unsigned secs, int unsigned max_secs);
        int unsigned r;
        r = (secs == 0) ? 1 : secs;
        return (r > max_secs) ? max_secs : r;
    endfunction

    function automatic int unsigned game_secs(int unsigned level, int unsigned base,
                                              int unsigned step, int unsigned min_secs,
                                              int unsigned max_secs);
        int unsigned drop;
        int unsigned secs;
        drop = level * step;
        if (drop >= base) begin
            secs = min_secs;
        end else begin
            secs = base - drop;
            if (secs < min_secs) secs = min_secs;
        end
        return clamp_secs(secs, max_secs);
    endfunction

endpackage

// File: rtl/game_phase_sequencer_if.sv
// Handshake bundle between the game top, Score/UserCount/Display and the sequencer.
// Carries pauseBtn only when SEQ_PAUSE_EN is defined.
interface game_phase_sequencer_if #(
    parameter int unsigned LEVEL_W = 4,
    parameter int unsigned TIME_W  = 6,
    parameter int unsigned DIFF_W  = 5
);
    logic              Clk1Hz;
    logic              startBtn;
    logic              answerDone;
    logic [DIFF_W-1:0] difference;
    logic              diffValid;
`ifdef SEQ_PAUSE_EN
    logic              pauseBtn;
`endif
    logic               pre;
    logic               game;
    logic               answer;
    logic               post;
    logic               lose;
    logic               win;
    logic               startGen;
    logic               stopGen;
    logic               stopCount;
    logic               newLevel;
    logic [LEVEL_W-1:0] curLevel;
    logic [TIME_W-1:0]  secondsLeft;

    modport master (
`ifdef SEQ_PAUSE_EN
        output pauseBtn,
`endif
        output Clk1Hz, startBtn, answerDone, difference, diffValid,
        input  pre, game, answer, post, lose, win,
        input  startGen, stopGen, stopCount, newLevel, curLevel, secondsLeft
    );

    modport slave (
`ifdef SEQ_PAUSE_EN
        input  pauseBtn,
`endif
        input  Clk1Hz, startBtn, answerDone, difference, diffValid,
        output pre, game, answer, post, lose, win,
        output startGen, stopGen, stopCount, newLevel, curLevel, secondsLeft
    );

endinterface

// File: rtl/game_phase_sequencer_tick_edge_detect.sv
// Two-flop synchroniser on the 1 Hz square wave plus a registered rising-edge pulse.
module tick_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic tick
);

    logic [2:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[1:0], din};
            tick <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/game_phase_sequencer.sv
// Round FSM: PRELIM/GAME/ANSWER/JUDGE/POST with LOSE/WIN, per-phase timer and levels.
// Optional pause input enabled by defining SEQ_PAUSE_EN.
module game_phase_sequencer
    import game_seq_pkg::*;
#(
    parameter int unsigned LEVEL_W        = 4,
    parameter int unsigned NUM_LEVELS     = 9,
    parameter int unsigned TIME_W         = 6,
    parameter int unsigned DIFF_W         = 5,
    parameter int unsigned PRELIM_SECS    = DEF_PRELIM_SECS,
    parameter int unsigned GAME_SECS_BASE = DEF_GAME_SECS_BASE,
    parameter int unsigned GAME_SECS_STEP = DEF_GAME_SECS_STEP,
    parameter int unsigned GAME_SECS_MIN  = DEF_GAME_SECS_MIN,
    parameter int unsigned ANSWER_SECS    = DEF_ANSWER_SECS,
    parameter int unsigned POST_SECS      = DEF_POST_SECS,
    parameter int unsigned TOLERANCE      = 0
) (
    input logic                  Clk100M,
    input logic                  reset,
    game_phase_sequencer_if.slave seq
);

    localparam int unsigned        TIME_MAX    = (1 << TIME_W) - 1;
    localparam logic [TIME_W-1:0]  PRELIM_LOAD = TIME_W'(clamp_secs(PRELIM_SECS, TIME_MAX));
    localparam logic [TIME_W-1:0]  ANSWER_LOAD = TIME_W'(clamp_secs(ANSWER_SECS, TIME_MAX));
    localparam logic [TIME_W-1:0]  POST_LOAD   = TIME_W'(clamp_secs(POST_SECS, TIME_MAX));
    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);

    phase_t             state, state_n;
    logic [LEVEL_W-1:0] level, level_n;
    logic [TIME_W-1:0]  secs, secs_n;
    logic [TIME_W-1:0]  game_load;
    logic               start_gen_n, stop_gen_n, stop_count_n, new_level_n;
    logic               start_gen_q, stop_gen_q, stop_count_q, new_level_q;
    logic [5:0]         flags_q;
    logic               tick, active, tick_eff, answer_eff, expire;
    logic [DIFF_W-1:0]  diff;
    logic               pass;

    tick_edge_detect u_tick (
        .clk  (Clk100M),
        .rst  (reset),
        .din  (seq.Clk1Hz),
        .tick (tick)
    );

`ifdef SEQ_PAUSE_EN
    logic paused;

    always_ff @(posedge Clk100M) begin
        if (reset)                                   paused <= 1'b0;
        else if (state_n != state)                   paused <= 1'b0;
        else if (seq.pauseBtn && is_timed(state))    paused <= ~paused;
    end

    assign active = ~paused;
`else
    assign active = 1'b1;
`endif

    assign tick_eff   = tick & active;
    assign answer_eff = seq.answerDone & active;
    assign expire     = tick_eff && (secs == TIME_W'(1));
    assign diff       = seq.difference;
    assign pass       = (32'(diff) <= TOLERANCE);
    assign game_load  = TIME_W'(game_secs(32'(level), GAME_SECS_BASE, GAME_SECS_STEP,
                                          GAME_SECS_MIN, TIME_MAX));

    always_comb begin
        state_n      = state;
        level_n      = level;
        secs_n       = secs;
        start_gen_n  = 1'b0;
        stop_gen_n   = 1'b0;
        stop_count_n = 1'b0;
        new_level_n  = 1'b0;
        case (state)
            IDLE: begin
                if (seq.startBtn) begin
                    state_n = PRELIM;
                    level_n = '0;
                    secs_n  = PRELIM_LOAD;
                end
            end
            PRELIM: begin
                if (expire) begin
                    state_n     = GAME;
                    secs_n      = game_load;
                    start_gen_n = 1'b1;
                end else if (tick_eff) begin
                    secs_n = secs - TIME_W'(1);
                end
            end
            GAME: begin
                if (expire) begin
                    state_n    = ANSWER;
                    secs_n     = ANSWER_LOAD;
                    stop_gen_n = 1'b1;
                end else if (tick_eff) begin
                    secs_n = secs - TIME_W'(1);
                end
            end
            ANSWER: begin
                // Expiry and an early answer in the same cycle merge into one exit.
                if (expire || answer_eff) begin
                    state_n      = JUDGE;
                    secs_n       = '0;
                    stop_count_n = 1'b1;
                end else if (tick_eff) begin
                    secs_n = secs - TIME_W'(1);
                end
            end
            JUDGE: begin
                secs_n = '0;
                if (seq.diffValid) begin
                    if (!pass) begin
                        state_n = LOSE;
                    end else if (level == LAST_LEVEL) begin
                        state_n = WIN;
                    end else begin
                        state_n = POST;
                        secs_n  = POST_LOAD;
                    end
                end
            end
            POST: begin
                if (expire) begin
                    state_n     = PRELIM;
                    level_n     = level + LEVEL_W'(1);
                    secs_n      = PRELIM_LOAD;
                    new_level_n = 1'b1;
                end else if (tick_eff) begin
                    secs_n = secs - TIME_W'(1);
                end
            end
            default: begin
                secs_n = '0;
                if (seq.startBtn) begin
                    state_n     = PRELIM;
                    level_n     = '0;
                    secs_n      = PRELIM_LOAD;
                    new_level_n = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            state        <= IDLE;
            level        <= '0;
            secs         <= '0;
            start_gen_q  <= 1'b0;
            stop_gen_q   <= 1'b0;
            stop_count_q <= 1'b0;
            new_level_q  <= 1'b0;
            flags_q      <= '0;
        end else begin
            state        <= state_n;
            level        <= level_n;
            secs         <= secs_n;
            start_gen_q  <= start_gen_n;
            stop_gen_q   <= stop_gen_n;
            stop_count_q <= stop_count_n;
            new_level_q  <= new_level_n;
            flags_q      <= {state_n == PRELIM, state_n == GAME, state_n == ANSWER,
                             state_n == POST, state_n == LOSE, state_n == WIN};
        end
    end

    assign seq.pre         = flags_q[5];
    assign seq.game        = flags_q[4];
    assign seq.answer      = flags_q[3];
    assign seq.post        = flags_q[2];
    assign seq.lose        = flags_q[1];
    assign seq.win         = flags_q[0];
    assign seq.startGen    = start_gen_q;
    assign seq.stopGen     = stop_gen_q;
    assign seq.stopCount   = stop_count_q;
    assign seq.newLevel    = new_level_q;
    assign seq.curLevel    = level;
    assign seq.secondsLeft = secs;

endmodule
